// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator: per-input VC arbitration, then per-output input arbitration.
// Define SA_ISLIP_EN to advance the input VC pointer only when the input also wins its output (iSLIP-style).
module switch_allocator #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM   = 2,
    localparam int VCW     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int PW      = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]        switch_request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][2:0]   out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VCW-1:0] downstream_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]        on_off_i,
    output logic [PORT_NUM-1:0]                    valid_sel_o,
    output logic [PORT_NUM-1:0][VCW-1:0]           vc_sel_o,
    output logic [PORT_NUM-1:0][PW-1:0]            xb_sel_o,
    output logic [PORT_NUM-1:0]                    xb_valid_o
);

    logic [PORT_NUM-1:0][VCW-1:0] in_ptr;
    logic [PORT_NUM-1:0][PW-1:0]  out_ptr;

    logic [PORT_NUM-1:0][VC_NUM-1:0] eligible;
    logic [PORT_NUM-1:0]             s1_valid;
    logic [PORT_NUM-1:0][VCW-1:0]    s1_vc;
    logic [PORT_NUM-1:0][2:0]        s1_port;
    logic [PORT_NUM-1:0]             grant_valid;
    logic [PORT_NUM-1:0][PW-1:0]     grant_sel;
    logic [PORT_NUM-1:0]             in_grant;
    logic [PORT_NUM-1:0]             in_adv;

    // A VC is eligible only if its output exists and the downstream VC has room.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                eligible[i][v] = 1'b0;
                if (switch_request_i[i][v] && (int'(out_port_i[i][v]) < PORT_NUM))
                    eligible[i][v] = on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            s1_valid[i] = 1'b0;
            s1_vc[i]    = '0;
            s1_port[i]  = '0;
            for (int k = 0; k < VC_NUM; k++) begin
                int idx;
                idx = (int'(in_ptr[i]) + k) % VC_NUM;
                if (!s1_valid[i] && eligible[i][idx]) begin
                    s1_valid[i] = 1'b1;
                    s1_vc[i]    = VCW'(idx);
                    s1_port[i]  = out_port_i[i][idx];
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            grant_valid[o] = 1'b0;
            grant_sel[o]   = '0;
            for (int k = 0; k < PORT_NUM; k++) begin
                int idx;
                idx = (int'(out_ptr[o]) + k) % PORT_NUM;
                if (!grant_valid[o] && s1_valid[idx] && (int'(s1_port[idx]) == o)) begin
                    grant_valid[o] = 1'b1;
                    grant_sel[o]   = PW'(idx);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            in_grant[i] = 1'b0;
            for (int o = 0; o < PORT_NUM; o++) begin
                if (grant_valid[o] && (int'(grant_sel[o]) == i))
                    in_grant[i] = 1'b1;
            end
`ifdef SA_ISLIP_EN
            in_adv[i] = in_grant[i];
`else
            in_adv[i] = s1_valid[i];
`endif
        end
    end

    // Outputs are forced to zero while reset is held so grants drop immediately.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            valid_sel_o[i] = in_grant[i] && !rst;
            vc_sel_o[i]    = valid_sel_o[i] ? s1_vc[i] : '0;
            xb_valid_o[i]  = grant_valid[i] && !rst;
            xb_sel_o[i]    = xb_valid_o[i] ? grant_sel[i] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ptr  <= '0;
            out_ptr <= '0;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (grant_valid[o])
                    out_ptr[o] <= PW'((int'(grant_sel[o]) + 1) % PORT_NUM);
            end
            for (int i = 0; i < PORT_NUM; i++) begin
                if (in_adv[i])
                    in_ptr[i] <= VCW'((int'(s1_vc[i]) + 1) % VC_NUM);
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios with literal expectations plus a per-cycle round-robin model.
module tb_switch_allocator;
    localparam int P   = 5;
    localparam int V   = 2;
    localparam int VCW = 1;
    localparam int PW  = 3;

    logic clk = 1'b0;
    logic rst;
    logic [P-1:0][V-1:0]          switch_request;
    logic [P-1:0][V-1:0][2:0]     out_port;
    logic [P-1:0][V-1:0][VCW-1:0] downstream_vc;
    logic [P-1:0][V-1:0]          on_off;
    logic [P-1:0]                 valid_sel;
    logic [P-1:0][VCW-1:0]        vc_sel;
    logic [P-1:0][PW-1:0]         xb_sel;
    logic [P-1:0]                 xb_valid;

    int n_tests  = 0;
    int n_failed = 0;

    // Model state: pointers as plain ints, per-cycle winners (-1 = none).
    int m_in_ptr[P];
    int m_out_ptr[P];
    int s1[P];
    int e_vc[P];
    int e_in[P];

    int seq2[5] = '{0, 2, 4, 0, 2};

    switch_allocator #(.PORT_NUM(P), .VC_NUM(V)) dut (
        .clk(clk),
        .rst(rst),
        .switch_request_i(switch_request),
        .out_port_i(out_port),
        .downstream_vc_i(downstream_vc),
        .on_off_i(on_off),
        .valid_sel_o(valid_sel),
        .vc_sel_o(vc_sel),
        .xb_sel_o(xb_sel),
        .xb_valid_o(xb_valid)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit eligible(int i, int v);
        if (!switch_request[i][v]) return 1'b0;
        if (int'(out_port[i][v]) >= P) return 1'b0;
        return on_off[out_port[i][v]][downstream_vc[i][v]];
    endfunction

    // Winner = eligible candidate with the smallest circular distance from the pointer.
    function automatic void model_eval();
        for (int i = 0; i < P; i++) begin
            int best;
            best = V;
            s1[i] = -1;
            for (int v = 0; v < V; v++) begin
                if (eligible(i, v) && ((v - m_in_ptr[i] + V) % V) < best) begin
                    best  = (v - m_in_ptr[i] + V) % V;
                    s1[i] = v;
                end
            end
        end
        for (int o = 0; o < P; o++) begin
            int best;
            best = P;
            e_in[o] = -1;
            for (int i = 0; i < P; i++) begin
                if (s1[i] >= 0 && int'(out_port[i][s1[i]]) == o && ((i - m_out_ptr[o] + P) % P) < best) begin
                    best    = (i - m_out_ptr[o] + P) % P;
                    e_in[o] = i;
                end
            end
        end
        for (int i = 0; i < P; i++) e_vc[i] = -1;
        for (int o = 0; o < P; o++) begin
            if (e_in[o] >= 0) e_vc[e_in[o]] = s1[e_in[o]];
        end
    endfunction

    initial begin
        logic [P-1:0]          ev_valid;
        logic [P-1:0][VCW-1:0] ev_vc;
        logic [P-1:0]          ex_valid;
        logic [P-1:0][PW-1:0]  ex_sel;
        for (int i = 0; i < P; i++) begin
            m_in_ptr[i]  = 0;
            m_out_ptr[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < P; i++) begin
                    m_in_ptr[i]  = 0;
                    m_out_ptr[i] = 0;
                    s1[i]   = -1;
                    e_vc[i] = -1;
                    e_in[i] = -1;
                end
            end else begin
                model_eval();
            end
            for (int i = 0; i < P; i++) begin
                ev_valid[i] = (e_vc[i] >= 0);
                ev_vc[i]    = (e_vc[i] >= 0) ? VCW'(e_vc[i]) : '0;
                ex_valid[i] = (e_in[i] >= 0);
                ex_sel[i]   = (e_in[i] >= 0) ? PW'(e_in[i]) : '0;
            end
            check_output("model valid_sel", int'(valid_sel), int'(ev_valid));
            check_output("model vc_sel", int'(vc_sel), int'(ev_vc));
            check_output("model xb_valid", int'(xb_valid), int'(ex_valid));
            check_output("model xb_sel", int'(xb_sel), int'(ex_sel));
            check_output("grant count balance", $countones(valid_sel), $countones(xb_valid));
            @(posedge clk);
            if (!rst) begin
                for (int o = 0; o < P; o++) begin
                    if (e_in[o] >= 0) m_out_ptr[o] = (e_in[o] + 1) % P;
                end
                for (int i = 0; i < P; i++) begin
`ifdef SA_ISLIP_EN
                    if (e_vc[i] >= 0) m_in_ptr[i] = (e_vc[i] + 1) % V;
`else
                    if (s1[i] >= 0) m_in_ptr[i] = (s1[i] + 1) % V;
`endif
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        switch_request = '0;
        out_port       = '0;
        downstream_vc  = '0;
    endtask

    task automatic set_vc(input int i, input int v, input int op, input int dvc);
        switch_request[i][v] = 1'b1;
        out_port[i][v]       = 3'(op);
        downstream_vc[i][v]  = VCW'(dvc);
    endtask

    task automatic apply_stimulus_contention();
        clear_inputs();
        on_off = '1;
        set_vc(0, 0, 1, 0);
        set_vc(2, 0, 1, 0);
        set_vc(4, 0, 1, 0);
    endtask

    initial begin
        rst = 1'b1;
        on_off = '0;
        apply_stimulus_contention();
        @(negedge clk);
        check_output("reset valid_sel", int'(valid_sel), 0);
        check_output("reset xb_valid", int'(xb_valid), 0);
        check_output("reset xb_sel", int'(xb_sel), 0);
        check_output("reset vc_sel", int'(vc_sel), 0);

        next_cycle();
        rst = 1'b0;
        clear_inputs();
        on_off = '0;

        // Single request, granted in the same cycle
        next_cycle();
        clear_inputs();
        on_off = '0;
        on_off[3] = 2'b01;
        set_vc(1, 0, 3, 0);
        @(negedge clk);
        check_output("single valid_sel[1]", int'(valid_sel[1]), 1);
        check_output("single vc_sel[1]", int'(vc_sel[1]), 0);
        check_output("single xb_valid[3]", int'(xb_valid[3]), 1);
        check_output("single xb_sel[3]", int'(xb_sel[3]), 1);

        // Three inputs fighting for output 1 rotate 0, 2, 4, 0, 2
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            apply_stimulus_contention();
            @(negedge clk);
            check_output("contention xb_sel[1]", int'(xb_sel[1]), seq2[c]);
            check_output("contention xb_valid[1]", int'(xb_valid[1]), 1);
            check_output("contention one valid_sel", $countones(valid_sel), 1);
        end

        // On/off gating
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            clear_inputs();
            on_off = '1;
            on_off[4] = 2'b01;
            set_vc(2, 1, 4, 1);
            @(negedge clk);
            check_output("gated valid_sel[2]", int'(valid_sel[2]), 0);
            check_output("gated xb_valid[4]", int'(xb_valid[4]), 0);
        end
        next_cycle();
        on_off[4] = 2'b11;
        @(negedge clk);
        check_output("ungated valid_sel[2]", int'(valid_sel[2]), 1);
        check_output("ungated vc_sel[2]", int'(vc_sel[2]), 1);
        check_output("ungated xb_sel[4]", int'(xb_sel[4]), 2);

        // Pointer policy: clear pointers, preload out_ptr[2]=1 via input 0 VC1
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        on_off = '1;
        set_vc(0, 1, 2, 0);
        @(negedge clk);
        check_output("preload xb_sel[2]", int'(xb_sel[2]), 0);
        check_output("preload vc_sel[0]", int'(vc_sel[0]), 1);
        next_cycle();
        clear_inputs();
        set_vc(0, 0, 2, 0);
        set_vc(0, 1, 2, 0);
        set_vc(1, 0, 2, 0);
        @(negedge clk);
        check_output("policy xb_sel[2]", int'(xb_sel[2]), 1);
        check_output("policy valid_sel[0]", int'(valid_sel[0]), 0);
        check_output("policy valid_sel[1]", int'(valid_sel[1]), 1);
        next_cycle();
        clear_inputs();
        set_vc(0, 0, 2, 0);
        set_vc(0, 1, 2, 0);
        @(negedge clk);
`ifdef SA_ISLIP_EN
        check_output("policy in_ptr[0] held", int'(vc_sel[0]), 0);
`else
        check_output("policy in_ptr[0] advanced", int'(vc_sel[0]), 1);
`endif

        // Illegal output port is never granted
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            clear_inputs();
            set_vc(3, 0, 7, 0);
            @(negedge clk);
            check_output("illegal valid_sel[3]", int'(valid_sel[3]), 0);
            check_output("illegal xb_valid", int'(xb_valid), 0);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            clear_inputs();
            set_vc(3, 0, 7, 0);
            set_vc(3, 1, 0, 0);
            @(negedge clk);
            check_output("legal valid_sel[3]", int'(valid_sel[3]), 1);
            check_output("legal vc_sel[3]", int'(vc_sel[3]), 1);
            check_output("legal xb_sel[0]", int'(xb_sel[0]), 3);
        end

        // Reset mid-operation
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            apply_stimulus_contention();
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_output("midreset valid_sel", int'(valid_sel), 0);
        check_output("midreset xb_valid", int'(xb_valid), 0);
        check_output("midreset xb_sel", int'(xb_sel), 0);
        check_output("midreset vc_sel", int'(vc_sel), 0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            rst = 1'b0;
            @(negedge clk);
            check_output("postreset xb_sel[1]", int'(xb_sel[1]), seq2[c]);
        end

        next_cycle();
        clear_inputs();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
